keypad_encoder: RTL
===================

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable cycles required to accept a press or a release (minimum 2).
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 16, meaning the held-key cycles between auto-repeat strobes (used only when auto-repeat is compiled in).
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clrn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port keypad, input, 10 bits: raw key lines, bit k high = digit key k pressed; synchronous to clock.
REQ-006 The block SHALL have port enablen, input, 1 bit: active-low entry enable; high blocks new key acceptance.
REQ-007 The block SHALL have port data, output, 4 bits: registered BCD code of the last accepted key.
REQ-008 The block SHALL have port loadn, output, 1 bit: registered active-low load strobe to the timer chain; low for one cycle per accepted key.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 Encoding SHALL be priority by lowest index: if several keypad bits are high, the code is the index of the lowest set bit; keypad == 0 means no key.
REQ-011 The FSM SHALL have states IDLE, DEBOUNCE, LOAD and WAIT_RELEASE.
REQ-012 In IDLE with enablen low and keypad != 0, the next state SHALL be DEBOUNCE, the encoded code SHALL be captured, and the stability counter SHALL be cleared.
REQ-013 In DEBOUNCE, each cycle in which the encoded code equals the captured code SHALL increment the counter; on reaching DEBOUNCE_CYCLES-1 the next state SHALL be LOAD.
REQ-014 In DEBOUNCE, a code change, keypad == 0, or enablen high SHALL return the FSM to IDLE with no strobe.
REQ-015 In LOAD, data SHALL equal the captured code and loadn SHALL be 0 for exactly that one cycle; data SHALL be valid no later than the cycle loadn goes low. The next state SHALL be WAIT_RELEASE.
REQ-016 In WAIT_RELEASE, the FSM SHALL return to IDLE only after keypad == 0 for DEBOUNCE_CYCLES consecutive cycles; any key activity restarts the release count.
REQ-017 Key-press latency, from the first high key sample to the loadn low cycle, SHALL be DEBOUNCE_CYCLES+1 cycles.
REQ-018 data SHALL hold its value between strobes; loadn SHALL be 1 in every state except LOAD.
REQ-019 enablen going high while in LOAD or WAIT_RELEASE SHALL NOT cancel an already-issued strobe or shorten the release wait.
REQ-020 Counters SHALL saturate and never wrap while a state is held.

Reset
REQ-021 When clrn is 0, the block SHALL asynchronously force: state IDLE, data 4'd0, loadn 1, busy 0, and all counters and captured code to 0.
REQ-022 A reset asserted mid-debounce or during LOAD SHALL suppress any pending or in-progress strobe.
REQ-023 After clrn deasserts, a key already held SHALL be treated as a fresh press from IDLE.

Configuration
REQ-024 Macro KEYPAD_AUTOREPEAT_EN SHALL select the auto-repeat behaviour.
- Defined: in WAIT_RELEASE, the same code held continuously for REPEAT_CYCLES cycles SHALL re-enter LOAD, issuing another strobe; this repeats every REPEAT_CYCLES+1 cycles while held and enablen is low.
- Undefined: exactly one strobe SHALL be issued per press, regardless of hold time.

Verification
REQ-025 (DEBOUNCE_CYCLES=4) keypad=10'b0000100000 held from cycle 0, enablen=0 -> data=5 and loadn=0 at cycle 5 only; busy high from cycle 1.
REQ-026 Key 3 pulsed high for 2 cycles only -> no loadn strobe; FSM back in IDLE; data unchanged from reset value 0.
REQ-027 keypad=10'b1000000010 (keys 1 and 9) held -> single strobe with data=1.
REQ-028 enablen=1 and key 7 held for 20 cycles -> loadn stays 1 and busy stays 0; enablen dropped to 0 -> strobe with data=7 five cycles later.
REQ-029 Key 2 held 40 cycles -> exactly one strobe without KEYPAD_AUTOREPEAT_EN; with it defined and REPEAT_CYCLES=16, strobes at cycles 5, 22 and 39.
REQ-030 clrn pulsed low at cycle 3 of a key 8 debounce -> no strobe, data=0, loadn=1; with key 8 still held, a strobe follows DEBOUNCE_CYCLES+1 cycles after clrn deasserts.

Source files
------------

// File: rtl/keypad_encoder.sv
// Debounced 10-key keypad to BCD encoder with a one-cycle active-low load strobe.
// Define KEYPAD_AUTOREPEAT_EN to re-strobe a held key every REPEAT_CYCLES+1 cycles.
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic [9:0] keypad,
  input  logic       enablen,
  output logic [3:0] data,
  output logic       loadn,
  output logic       busy
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, LOAD, WAIT_RELEASE} state_t;

  state_t        state, state_nx;
  logic [3:0]    code_q, code_nx, enc;
  logic          key;
  logic [CW-1:0] cnt_q, cnt_nx;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rpt_q, rpt_nx;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // Lowest set index wins; scan downward so the last hit is the lowest.
  always_comb begin
    enc = '0;
    for (int k = 9; k >= 0; k--)
      if (keypad[k]) enc = 4'(k);
    key = |keypad;
  end

  // cnt_q counts stable press cycles in DEBOUNCE and quiet cycles in WAIT_RELEASE.
  always_comb begin
    state_nx = state;
    code_nx  = code_q;
    cnt_nx   = cnt_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_nx   = rpt_q;
`endif
    case (state)
      IDLE: begin
        if (!enablen && key) begin
          state_nx = DEBOUNCE;
          code_nx  = enc;
          cnt_nx   = '0;
        end
      end
      DEBOUNCE: begin
        if (enablen || !key || enc != code_q) state_nx = IDLE;
        else if (cnt_q >= DB_LAST)            state_nx = LOAD;
        else                                  cnt_nx   = sat_inc(cnt_q);
      end
      LOAD: begin
        state_nx = WAIT_RELEASE;
        cnt_nx   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rpt_nx   = '0;
`endif
      end
      WAIT_RELEASE: begin
        if (key)                   cnt_nx   = '0;
        else if (cnt_q >= DB_LAST) state_nx = IDLE;
        else                       cnt_nx   = sat_inc(cnt_q);
`ifdef KEYPAD_AUTOREPEAT_EN
        if (key && enc == code_q && !enablen) begin
          if (rpt_q >= RP_LAST) state_nx = LOAD;
          else                  rpt_nx   = sat_inc(rpt_q);
        end else begin
          rpt_nx = '0;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered off the next state so data and loadn land together.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      code_q <= '0;
      cnt_q  <= '0;
      data   <= '0;
      loadn  <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q  <= '0;
`endif
    end else begin
      state  <= state_nx;
      code_q <= code_nx;
      cnt_q  <= cnt_nx;
      loadn  <= (state_nx != LOAD);
      if (state_nx == LOAD) data <= code_q;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q  <= rpt_nx;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule
